// File: rtl/mdu_pkg.sv
// Shared encodings and types for the iterative multiply/divide unit.
// Latency: none (constants and types only).
// Backpressure: none.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = MDU_WIDTH;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_abs.sv
// Conditional two's-complement negate: out = neg ? -in : in.
// Latency: combinational.
// Backpressure: none.
module mdu_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = neg_i ? ((~in_i) + WIDTH'(1)) : in_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers, plus MTHI/MTLO writes.
// Latency: 33 cycles per mult/div (ITER steps + sign fix); MTHI/MTLO one cycle.
// Backpressure: Busy high while an op runs, Start ignored; Run=0 freezes all state.
// Optional: define MDU_SIGNED_EN for two's-complement MULT/DIV (otherwise they act as MULTU/DIVU).
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Run,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int            CW       = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Upper half: partial product / remainder. Lower half: multiplier / dividend -> quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand or divisor magnitude.
  logic [WIDTH-1:0]   b_q, b_d;
  logic               div_q, div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic               load;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MDU_SIGNED_EN
  logic sa_q, sb_q;
  logic op_signed;

  assign op_signed = (Op == OP_MULT) || (Op == OP_DIV);

  mdu_abs #(.WIDTH(WIDTH)) u_abs_a (
    .in_i  (busA),
    .neg_i (op_signed & busA[WIDTH-1]),
    .out_o (a_mag)
  );

  mdu_abs #(.WIDTH(WIDTH)) u_abs_b (
    .in_i  (busB),
    .neg_i (op_signed & busB[WIDTH-1]),
    .out_o (b_mag)
  );

  mdu_abs #(.WIDTH(2*WIDTH)) u_fix_prod (
    .in_i  (acc_q),
    .neg_i (sa_q ^ sb_q),
    .out_o (prod_fix)
  );

  mdu_abs #(.WIDTH(WIDTH)) u_fix_quo (
    .in_i  (acc_q[WIDTH-1:0]),
    .neg_i (sa_q ^ sb_q),
    .out_o (quo_fix)
  );

  // Remainder follows the sign of the dividend.
  mdu_abs #(.WIDTH(WIDTH)) u_fix_rem (
    .in_i  (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i (sa_q),
    .out_o (rem_fix)
  );

  // Capture operand signs when a mult/div is accepted.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (load) begin
      sa_q <= op_signed & busA[WIDTH-1];
      sb_q <= op_signed & busB[WIDTH-1];
    end
  end
`else
  assign a_mag    = busA;
  assign b_mag    = busB;
  assign prod_fix = acc_q;
  assign quo_fix  = acc_q[WIDTH-1:0];
  assign rem_fix  = acc_q[2*WIDTH-1:WIDTH];
`endif

  // One shift-add step: conditionally add multiplicand to the upper half, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring step: shift in next dividend bit, keep the difference if it did not borrow.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_trial = rem_sh - {1'b0, b_q};
  assign div_next  = div_trial[WIDTH]
                   ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Next-state and datapath control; everything holds while Run is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = done_q;
    dz_d    = dz_q;
    load    = 1'b0;
    if (Run) begin
      done_d = 1'b0;
      dz_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            case (Op)
              OP_MULT, OP_MULTU: begin
                load    = 1'b1;
                div_d   = 1'b0;
                state_d = ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                if (busB == {WIDTH{1'b0}}) begin
                  done_d = 1'b1;
                  dz_d   = 1'b1;
                end else begin
                  load    = 1'b1;
                  div_d   = 1'b1;
                  state_d = ST_DIV;
                end
              end
              OP_MTHI: hi_d = busA;
              OP_MTLO: lo_d = busA;
              default: ;
            endcase
            if (load) begin
              acc_d = {{WIDTH{1'b0}}, a_mag};
              b_d   = b_mag;
              cnt_d = '0;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          acc_d = (state_q == ST_MUL) ? mul_next : div_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          if (div_q) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign Busy    = (state_q != ST_IDLE);
  assign Done    = done_q;
  assign DivZero = dz_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a transaction-level model.
// Model: results from plain integer arithmetic, timing from a busy-cycle countdown.
// Outputs compared on every falling edge.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int OP_CYCLES = 32 + 1;

  logic        clk = 1'b0;
  logic        rst_n, run, start;
  logic [2:0]  op;
  logic [31:0] bus_a, bus_b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .Clk     (clk),
    .Rst_n   (rst_n),
    .Run     (run),
    .Start   (start),
    .Op      (op),
    .busA    (bus_a),
    .busB    (bus_b),
    .Busy    (busy),
    .Done    (done),
    .DivZero (div_zero),
    .Hi      (hi),
    .Lo      (lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
  int          m_left = 0;

  function automatic void calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb;
    logic [63:0] t, q, r;
    bit          sgn;
    sgn = 1'b0;
`ifdef MDU_SIGNED_EN
    sgn = (o == OP_MULT) || (o == OP_DIV);
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (o == OP_MULT || o == OP_MULTU) begin
      t  = 64'(sa * sb);
      rh = t[63:32];
      rl = t[31:0];
    end else begin
      q  = 64'(sa / sb);
      r  = 64'(sa % sb);
      rl = q[31:0];
      rh = r[31:0];
    end
  endfunction

  task automatic model_step();
    logic [31:0] rh, rl;
    if (!rst_n) begin
      m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else if (run) begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_rhi; m_lo = m_rlo; m_done = 1'b1;
        end
      end else if (start) begin
        case (op)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            if ((op == OP_DIV || op == OP_DIVU) && bus_b == 32'd0) begin
              m_done = 1'b1; m_dz = 1'b1;
            end else begin
              calc(op, bus_a, bus_b, rh, rl);
              m_rhi = rh; m_rlo = rl; m_left = OP_CYCLES;
            end
          end
          OP_MTHI: m_hi = bus_a;
          OP_MTLO: m_lo = bus_a;
          default: ;
        endcase
      end
    end
    m_busy = (m_left > 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("busy",    32'(busy),     32'(m_busy));
      chk("done",    32'(done),     32'(m_done));
      chk("divzero", 32'(div_zero), 32'(m_dz));
      chk("hi",      hi,            m_hi);
      chk("lo",      lo,            m_lo);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; bus_a = a; bus_b = b;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
  endtask

  task automatic wait_idle(input string name, output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s: busy still high after %0d cycles", name, cycles);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0; run = 1'b1; start = 1'b0; op = OP_NOP; bus_a = '0; bus_b = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz",   32'(div_zero), 32'd0);
    chk("rst_hi",   hi, 32'd0);
    chk("rst_lo",   lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU all-ones squared: 33 busy cycles, single Done pulse
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("multu_ff", n);
    chk("multu_ff_busy_len", 32'(n), 32'd33);
    chk("multu_ff_done", 32'(done), 32'd1);
    chk("multu_ff_hi", hi, 32'hFFFF_FFFE);
    chk("multu_ff_lo", lo, 32'h0000_0001);
    @(negedge clk);
    chk("multu_ff_done_low", 32'(done), 32'd0);

    // MULT -3 x 5
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_idle("mult_neg", n);
`ifdef MDU_SIGNED_EN
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
`else
    chk("mult_neg_hi", hi, 32'h0000_0004);
`endif
    chk("mult_neg_lo", lo, 32'hFFFF_FFF1);

    // DIV -7 / 2
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_neg", n);
`ifdef MDU_SIGNED_EN
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
`else
    chk("div_neg_lo", lo, 32'h7FFF_FFFC);
    chk("div_neg_hi", hi, 32'h0000_0001);
`endif

    // DIVU 100 / 7
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle("divu_100_7", n);
    chk("divu_100_7_lo", lo, 32'd14);
    chk("divu_100_7_hi", hi, 32'd2);

    // Most negative / -1
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf", n);
`ifdef MDU_SIGNED_EN
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);
`else
    chk("div_ovf_lo", lo, 32'h0000_0000);
    chk("div_ovf_hi", hi, 32'h8000_0000);
`endif

    // MTHI/MTLO then divide by zero: Hi/Lo untouched, Busy never high
    issue(OP_MTHI, 32'h1234, 32'd0);
    chk("mthi", hi, 32'h1234);
    issue(OP_MTLO, 32'h5678, 32'd0);
    chk("mtlo", lo, 32'h5678);
    issue(OP_DIVU, 32'd7, 32'd0);
    chk("dz_busy", 32'(busy), 32'd0);
    chk("dz_done", 32'(done), 32'd1);
    chk("dz_flag", 32'(div_zero), 32'd1);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_lo", lo, 32'h5678);
    @(negedge clk);
    chk("dz_done_low", 32'(done), 32'd0);
    chk("dz_flag_low", 32'(div_zero), 32'd0);
    chk("dz_busy_low", 32'(busy), 32'd0);

    // MULTU 6 x 7 with an ignored MTHI and a five-cycle Run stall
    issue(OP_MULTU, 32'd6, 32'd7);
    n = 0;
    for (int c = 1; c < 300 && busy; c++) begin
      n++;
      start = (c == 5);
      op    = (c == 5) ? OP_MTHI : OP_NOP;
      bus_a = 32'hDEAD_BEEF;
      run   = !(c >= 10 && c <= 14);
      @(negedge clk);
    end
    start = 1'b0; op = OP_NOP; run = 1'b1;
    chk("stall_busy_len", 32'(n), 32'd38);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_lo", lo, 32'd42);
    chk("stall_hi", hi, 32'd0);
    // Done holds through Run=0 and clears once Run returns
    run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("done_hold", 32'(done), 32'd1);
    end
    run = 1'b1;
    @(negedge clk);
    chk("done_release", 32'(done), 32'd0);

    // Reset mid-DIVU aborts, then MTLO straight after reset
    issue(OP_DIVU, 32'h0123_4567, 32'd3);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    rst_n = 1'b1;
    issue(OP_MTLO, 32'hABCD, 32'd0);
    chk("post_rst_mtlo", lo, 32'hABCD);

    // Randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 3'($urandom_range(0, 7));
      bus_a = pick();
      bus_b = pick();
      run   = ($urandom_range(0, 7) != 0);
      rst_n = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end
    start = 1'b0; run = 1'b1; rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
